// File: rtl/stage_fifo.sv
// Elastic valid/ready FIFO between pipeline stages.
// Registered in_ready/out_valid; flush drops every stored entry.
module stage_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int AFULL_TH = DEPTH-1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_payload,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             afull_q, afull_d;
  logic             push, pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH-1)) nxt = '0;
    else                   nxt = p + PW'(1);
  endfunction

  always_comb begin
    push    = in_valid & in_ready_q;
    pop     = out_valid_q & out_ready;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = nxt(wptr_q);
      if (pop)  rptr_d = nxt(rptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    // status flags come from next-state count so they line up with count
    in_ready_d  = (count_d != CW'(DEPTH));
    out_valid_d = (count_d != '0);
    afull_d     = (count_d >= CW'(AFULL_TH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= in_payload;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_payload = mem_q[rptr_q];
  assign count       = count_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_stage_fifo.sv
// Directed bench for stage_fifo at DEPTH 2, 3 and 4.
// Shared stimulus; each phase resets and checks one instance.
module tb_stage_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] pd;
  logic        iv;
  logic        ordy;

  logic        ir2, ov2, af2;
  logic [31:0] op2;
  logic [1:0]  c2;
  logic        ir4, ov4, af4;
  logic [31:0] op4;
  logic [2:0]  c4;
  logic        ir3, ov3, af3;
  logic [31:0] op3;
  logic [1:0]  c3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_fifo #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_payload(pd), .in_valid(iv), .in_ready(ir2),
    .out_payload(op2), .out_valid(ov2), .out_ready(ordy),
    .count(c2), .almost_full(af2)
  );

  stage_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_TH(3)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_payload(pd), .in_valid(iv), .in_ready(ir4),
    .out_payload(op4), .out_valid(ov4), .out_ready(ordy),
    .count(c4), .almost_full(af4)
  );

  stage_fifo #(.WIDTH(32), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_payload(pd), .in_valid(iv), .in_ready(ir3),
    .out_payload(op3), .out_valid(ov3), .out_ready(ordy),
    .count(c3), .almost_full(af3)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (c2 > 2 || c3 > 3 || c4 > 4) begin
        errors++;
        $display("FAIL bound c2=%0d c3=%0d c4=%0d max 2/3/4",
                 c2, c3, c4);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    pd    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pd;
    logic        ordy;
    int          cnt;
    logic        ir;
    logic        ov;
    logic [31:0] pay;
    logic        af;
  } vec_t;

  vec_t tbl [12];
  int   q [$];

  initial begin
    // {flush, in_valid, payload, out_ready, count, in_ready, out_valid, payload, afull}
    tbl[0]  = '{0, 1, 32'hA,  0, 0, 1, 0, 32'h0, 0};
    tbl[1]  = '{0, 1, 32'hB,  0, 1, 1, 1, 32'hA, 1};
    tbl[2]  = '{0, 0, 32'h0,  0, 2, 0, 1, 32'hA, 1};
    tbl[3]  = '{0, 1, 32'hC,  1, 2, 0, 1, 32'hA, 1};
    tbl[4]  = '{0, 0, 32'h0,  1, 1, 1, 1, 32'hB, 1};
    tbl[5]  = '{0, 0, 32'h0,  1, 0, 1, 0, 32'h0, 0};
    tbl[6]  = '{0, 1, 32'hD,  1, 0, 1, 0, 32'h0, 0};
    tbl[7]  = '{0, 1, 32'hE,  1, 1, 1, 1, 32'hD, 1};
    tbl[8]  = '{0, 0, 32'h0,  0, 1, 1, 1, 32'hE, 1};
    tbl[9]  = '{1, 1, 32'h55, 1, 1, 1, 1, 32'hE, 1};
    tbl[10] = '{0, 0, 32'h0,  1, 0, 1, 0, 32'h0, 0};
    tbl[11] = '{0, 1, 32'h77, 0, 0, 1, 0, 32'h0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      flush = tbl[i].fl;
      iv    = tbl[i].iv;
      pd    = tbl[i].pd;
      ordy  = tbl[i].ordy;
      chk($sformatf("d2_cnt[%0d]", i), 32'(c2), 32'(tbl[i].cnt));
      chk($sformatf("d2_ir[%0d]", i), 32'(ir2), 32'(tbl[i].ir));
      chk($sformatf("d2_ov[%0d]", i), 32'(ov2), 32'(tbl[i].ov));
      chk($sformatf("d2_af[%0d]", i), 32'(af2), 32'(tbl[i].af));
      if (tbl[i].ov)
        chk($sformatf("d2_pay[%0d]", i), op2, tbl[i].pay);
      step();
    end
    flush = 1'b0;
    iv    = 1'b0;
    chk("d2_after_flush_push", op2, 32'h77);

    // streaming 1..100 through DEPTH=4
    do_reset();
    iv   = 1'b1;
    ordy = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      pd = 32'(k);
      if (k == 101) iv = 1'b0;
      if (k == 1) begin
        chk("d4_fill_ov", 32'(ov4), 0);
      end else begin
        chk($sformatf("d4_str_pay[%0d]", k), op4, 32'(k-1));
        chk($sformatf("d4_str_cnt[%0d]", k), 32'(c4), 1);
        chk($sformatf("d4_str_ir[%0d]", k), 32'(ir4), 1);
        chk($sformatf("d4_str_af[%0d]", k), 32'(af4), 0);
      end
      step();
    end
    chk("d4_drain_ov", 32'(ov4), 0);

    // almost_full at count 3, cleared after one pop
    do_reset();
    ordy = 1'b0;
    iv   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pd = 32'h11 * (k+1);
      chk($sformatf("d4_af_pre[%0d]", k), 32'(af4), 0);
      step();
    end
    iv = 1'b0;
    chk("d4_cnt3", 32'(c4), 3);
    chk("d4_af3", 32'(af4), 1);
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk("d4_cnt2", 32'(c4), 2);
    chk("d4_af2", 32'(af4), 0);
    chk("d4_head", op4, 32'h22);

    // flush at count 3 with a simultaneous push of 0x55
    iv = 1'b1;
    pd = 32'h33;
    step();
    chk("d4_pre_flush", 32'(c4), 3);
    flush = 1'b1;
    pd    = 32'h55;
    step();
    flush = 1'b0;
    iv    = 1'b0;
    chk("d4_fl_cnt", 32'(c4), 0);
    chk("d4_fl_ov", 32'(ov4), 0);
    chk("d4_fl_ir", 32'(ir4), 1);
    chk("d4_fl_af", 32'(af4), 0);
    iv = 1'b1;
    pd = 32'h66;
    step();
    iv   = 1'b0;
    ordy = 1'b1;
    chk("d4_fl_next", op4, 32'h66);
    chk("d4_fl_next_cnt", 32'(c4), 1);
    step();
    chk("d4_fl_empty", 32'(ov4), 0);

    // DEPTH=3 with random stalls against a queue model
    do_reset();
    q.delete();
    begin
      int nxt = 1;
      int got = 0;
      int cyc = 0;
      while (got < 10 && cyc < 500) begin
        bit mpush, mpop;
        iv   = ($urandom_range(0, 3) != 0) && (nxt <= 10);
        ordy = ($urandom_range(0, 2) != 0);
        pd   = 32'(nxt);
        chk("d3_cnt", 32'(c3), 32'(q.size()));
        chk("d3_ov", 32'(ov3), 32'(q.size() > 0));
        chk("d3_ir", 32'(ir3), 32'(q.size() < 3));
        if (q.size() > 0) chk("d3_pay", op3, 32'(q[0]));
        mpush = iv && (q.size() < 3);
        mpop  = ordy && (q.size() > 0);
        if (mpop) begin
          void'(q.pop_front());
          got++;
        end
        if (mpush) begin
          q.push_back(nxt);
          nxt++;
        end
        step();
        cyc++;
      end
      if (got < 10) begin
        errors++;
        $display("FAIL d3_timeout got=%0d want=10", got);
      end
    end
    iv   = 1'b0;
    ordy = 1'b0;

    // asynchronous reset mid-burst
    do_reset();
    iv = 1'b1;
    pd = 32'hC1;
    step();
    pd = 32'hC2;
    step();
    iv = 1'b0;
    chk("rst_pre_cnt", 32'(c2), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ov", 32'(ov2), 0);
    chk("rst_async_cnt", 32'(c2), 0);
    chk("rst_async_ir", 32'(ir2), 1);
    #4;
    rst_n = 1'b1;
    step();
    chk("rst_post_cnt", 32'(c2), 0);
    chk("rst_post_ir", 32'(ir2), 1);
    chk("rst_post_ov", 32'(ov2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
